// File: rtl/cla_share_arbiter.sv
// Round-robin arbiter sharing one 32-bit carry-lookahead adder between two
// valid/ready requesters, with a registered response slot and grant counters.

module cla_adder (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        ci,
   output logic [31:0] s,
   output logic        co
);
   localparam int unsigned N = 32;

   logic [N-1:0] g;
   logic [N-1:0] p;
   logic [N:0]   c;

   assign g = a & b;
   assign p = a ^ b;

   // Full lookahead inside each 4-bit group; group carry chains group to group.
   always_comb begin
      c    = '0;
      c[0] = ci;
      for (int i = 0; i < 8; i++) begin
         c[4*i+1] = g[4*i] | (p[4*i] & c[4*i]);
         c[4*i+2] = g[4*i+1] | (p[4*i+1] & g[4*i])
                  | (p[4*i+1] & p[4*i] & c[4*i]);
         c[4*i+3] = g[4*i+2] | (p[4*i+2] & g[4*i+1])
                  | (p[4*i+2] & p[4*i+1] & g[4*i])
                  | (p[4*i+2] & p[4*i+1] & p[4*i] & c[4*i]);
         c[4*i+4] = g[4*i+3] | (p[4*i+3] & g[4*i+2])
                  | (p[4*i+3] & p[4*i+2] & g[4*i+1])
                  | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i])
                  | (p[4*i+3] & p[4*i+2] & p[4*i+1] & p[4*i] & c[4*i]);
      end
   end

   assign s  = p ^ c[N-1:0];
   assign co = c[N];
endmodule

module cla_share_arbiter #(
   parameter int unsigned W  = 32,
   parameter int unsigned CW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0_valid,
   output logic          req0_ready,
   input  logic [W-1:0]  req0_a,
   input  logic [W-1:0]  req0_b,
   input  logic          req0_ci,
   input  logic          req1_valid,
   output logic          req1_ready,
   input  logic [W-1:0]  req1_a,
   input  logic [W-1:0]  req1_b,
   input  logic          req1_ci,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [W-1:0]  rsp_sum,
   output logic          rsp_co,
   output logic          rsp_id,
   output logic [CW-1:0] gnt0_cnt,
   output logic [CW-1:0] gnt1_cnt
);
   logic         last;
   logic         free_c;
   logic         gnt0_c;
   logic         gnt1_c;
   logic         accept_c;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         op_ci;
   logic [W-1:0] cla_s;
   logic         cla_co;

   assign free_c = !rsp_valid | rsp_ready;

   // Under contention the requester that did not win last time is granted.
   always_comb begin
      gnt0_c = 1'b0;
      gnt1_c = 1'b0;
      if (free_c) begin
         if (req0_valid && (!req1_valid || last))
            gnt0_c = 1'b1;
         else if (req1_valid)
            gnt1_c = 1'b1;
      end
   end

   assign accept_c   = gnt0_c | gnt1_c;
   assign req0_ready = gnt0_c;
   assign req1_ready = gnt1_c;

   assign op_a  = gnt1_c ? req1_a  : req0_a;
   assign op_b  = gnt1_c ? req1_b  : req0_b;
   assign op_ci = gnt1_c ? req1_ci : req0_ci;

   cla_adder u_cla (
      .a  (op_a),
      .b  (op_b),
      .ci (op_ci),
      .s  (cla_s),
      .co (cla_co)
   );

   // Response slot and round-robin pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid <= 1'b0;
         rsp_sum   <= '0;
         rsp_co    <= 1'b0;
         rsp_id    <= 1'b0;
         last      <= 1'b1;
      end else if (accept_c) begin
         rsp_valid <= 1'b1;
         rsp_sum   <= cla_s;
         rsp_co    <= cla_co;
         rsp_id    <= gnt1_c;
         last      <= gnt1_c;
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

   // Saturating grant counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt0_cnt <= '0;
         gnt1_cnt <= '0;
      end else begin
         if (gnt0_c && (gnt0_cnt != {CW{1'b1}}))
            gnt0_cnt <= gnt0_cnt + CW'(1);
         if (gnt1_c && (gnt1_cnt != {CW{1'b1}}))
            gnt1_cnt <= gnt1_cnt + CW'(1);
      end
   end
endmodule

// File: doc/cla_share_arbiter.md
Name: cla_share_arbiter

Overview:
Shares one 32-bit CLA adder instance between two independent requesters. Uses round-robin arbitration with valid/ready handshakes on both request ports and on a single registered response port. Keeps saturating per-requester grant counters for performance debug. Sits between requesting datapath blocks and the instantiated CLA; requesters never drive the adder directly.

Parameters:
W, 32, operand width; must equal the CLA operand width, and no other value is supported.
CW, 16, width of each grant counter.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous reset, active-high.
req0_valid  in  1  requester 0 has an operation.
req0_ready  out  1  requester 0 operation accepted this cycle (handshake = valid & ready).
req0_a  in  W  operand a, requester 0.
req0_b  in  W  operand b, requester 0.
req0_ci  in  1  carry-in, requester 0.
req1_valid / req1_ready / req1_a / req1_b / req1_ci: same as requester 0, for requester 1.
rsp_valid  out  1  result register holds an unconsumed result.
rsp_ready  in  1  consumer accepts the result.
rsp_sum  out  W  registered sum, taken from s[W-1:0] of the CLA.
rsp_co  out  1  registered carry-out, taken from co of the CLA.
rsp_id  out  1  requester index (0 or 1) that produced the result.
gnt0_cnt  out  CW  number of accepted requester-0 operations; saturates at all-ones.
gnt1_cnt  out  CW  number of accepted requester-1 operations; saturates at all-ones.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - rsp_valid=0, rsp_sum=0, rsp_co=0, rsp_id=0.
  - gnt0_cnt=0, gnt1_cnt=0.
  - Round-robin pointer last=1, so requester 0 wins the first contention.
  - Any in-flight result is discarded.
- Slot free: free = !rsp_valid | rsp_ready. No operation is accepted unless free=1.
- Grant (combinational, decided within the cycle):
  - Only one valid → that requester is granted if free.
  - Both valid → the requester other than last is granted.
  - At most one of req0_ready/req1_ready is high in any cycle.
  - ready depends on valid of both ports and on rsp_ready. A requester may hold valid without ready for any number of cycles; it must keep its operands stable while waiting.
- Datapath: the granted port's a, b, ci are muxed to the CLA. On the accept edge:
  - rsp_sum <= s[W-1:0], rsp_co <= co, rsp_id <= granted index.
  - rsp_valid <= 1; last <= granted index.
- Latency: exactly 1 cycle from accept edge to rsp_valid=1.
- Throughput: 1 operation per cycle while rsp_ready stays high; back-to-back accepts alternate between requesters under contention.
- Consume without a new accept: rsp_valid <= 0; rsp_sum, rsp_co, rsp_id keep their old values.
- Consume and accept in the same cycle: the result register reloads with the new result and rsp_valid stays 1.
- Stall: rsp_valid=1 and rsp_ready=0 → all outputs hold, both ready lines are 0, the pointer does not move.
- Counters: the granted requester's counter increments on each accept. It holds at 2^CW-1 and never wraps.
- Arithmetic: unsigned W-bit add. Overflow is reported only through rsp_co. The result is never truncated silently beyond W bits.

Test Plan:
- Single op: rst pulse, then req0 a=9, b=4, ci=0 valid for one cycle with rsp_ready=1 → req0_ready=1 that cycle; next cycle rsp_valid=1, rsp_sum=13, rsp_co=0, rsp_id=0, gnt0_cnt=1.
- Carry: req1 a=32'hFFFFFFFF, b=1, ci=1 → rsp_sum=1, rsp_co=1, rsp_id=1.
- Contention: both valid continuously for 4 cycles with rsp_ready=1 → grants 0,1,0,1; rsp_id follows one cycle later; gnt0_cnt=2, gnt1_cnt=2.
- Backpressure: rsp_ready=0 after the first result, both requesters valid for 3 cycles → rsp_valid, rsp_sum, rsp_id frozen, both ready=0, pointer unchanged; rsp_ready=1 → the held result is consumed and the next grant goes to the non-last requester in that same cycle.
- Reset mid-operation: assert rst asynchronously (not clock-aligned) while rsp_valid=1 → rsp_valid=0, counters=0 immediately; after release, the first contention grants requester 0.
- Saturation: force 2^CW+3 accepts on req0 (CW=4 build) → gnt0_cnt stops at 15; gnt1_cnt stays 0.
